// File: rtl/fft_pair_buf.sv
// fft_pair_buf: input buffer for one radix-2 SDF stage.
// The first half of each frame (d_eff vectors) is stored in a row array.
// Each vector of the second half is paired with the vector pushed d_eff
// pushes earlier, and the pair is registered out for the butterfly.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   cfg_depth           half-frame depth, sampled on the first push of a frame
//                       (0 or > MAX_DEPTH selects MAX_DEPTH)
//   flush               synchronous abort, takes priority over din_valid
//   din_valid, din_i/q  input vector, LANES signed I/Q samples
//   dout_a_i/q          stored (earlier) vector of the pair
//   dout_b_i/q          current (later) vector of the pair
//   bfly_en             dout_a/dout_b hold a valid pair
//   frame_done          pulse with the last pair of a frame
//   busy                a frame is partially received

// Per-lane storage and output registers. All lanes share one address stream.
module fft_pair_lane #(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_DEPTH  = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [DATA_WIDTH-1:0] din_q,
  output logic [DATA_WIDTH-1:0] a_i,
  output logic [DATA_WIDTH-1:0] a_q,
  output logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] b_q
);
  logic [MAX_DEPTH-1:0][DATA_WIDTH-1:0] mem_i_q, mem_i_d;
  logic [MAX_DEPTH-1:0][DATA_WIDTH-1:0] mem_q_q, mem_q_d;
  logic [DATA_WIDTH-1:0] a_i_q, a_i_d, a_q_q, a_q_d;
  logic [DATA_WIDTH-1:0] b_i_q, b_i_d, b_q_q, b_q_d;

  always_comb begin
    mem_i_d = mem_i_q;
    mem_q_d = mem_q_q;
    a_i_d   = a_i_q;
    a_q_d   = a_q_q;
    b_i_d   = b_i_q;
    b_q_d   = b_q_q;
    if (wr_en) begin
      mem_i_d[wr_addr] = din_i;
      mem_q_d[wr_addr] = din_q;
    end
    if (rd_en) begin
      a_i_d = mem_i_q[rd_addr];
      a_q_d = mem_q_q[rd_addr];
      b_i_d = din_i;
      b_q_d = din_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_i_q <= '0;
      mem_q_q <= '0;
      a_i_q   <= '0;
      a_q_q   <= '0;
      b_i_q   <= '0;
      b_q_q   <= '0;
    end else begin
      mem_i_q <= mem_i_d;
      mem_q_q <= mem_q_d;
      a_i_q   <= a_i_d;
      a_q_q   <= a_q_d;
      b_i_q   <= b_i_d;
      b_q_q   <= b_q_d;
    end
  end

  assign a_i = a_i_q;
  assign a_q = a_q_q;
  assign b_i = b_i_q;
  assign b_q = b_q_q;
endmodule

module fft_pair_buf #(
  parameter int DATA_WIDTH = 9,
  parameter int LANES      = 16,
  parameter int MAX_DEPTH  = 16,
  parameter int DW         = $clog2(MAX_DEPTH+1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [DW-1:0]                    cfg_depth,
  input  logic                             flush,
  input  logic                             din_valid,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] din_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] din_q,
  output logic [LANES-1:0][DATA_WIDTH-1:0] dout_a_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0] dout_a_q,
  output logic [LANES-1:0][DATA_WIDTH-1:0] dout_b_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0] dout_b_q,
  output logic                             bfly_en,
  output logic                             frame_done,
  output logic                             busy
);
  // Phase must reach 2*MAX_DEPTH-1, and 2*d_eff itself is formed in this width.
  localparam int PW = $clog2(2*MAX_DEPTH+1);
  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] depth_r_q, depth_r_d;
  logic          bfly_en_q, bfly_en_d;
  logic          frame_done_q, frame_done_d;

  logic [DW-1:0] depth_clamp, d_eff;
  logic [PW-1:0] d_eff_w, last_ph;
  logic          push, fill, pair, last;
  logic [AW-1:0] wr_addr, rd_addr;

  always_comb begin
    depth_clamp = cfg_depth;
    if (cfg_depth == '0 || cfg_depth > DW'(MAX_DEPTH)) depth_clamp = DW'(MAX_DEPTH);
    // The first push of a frame already runs with the freshly sampled depth.
    d_eff   = (phase_q == '0) ? depth_clamp : depth_r_q;
    d_eff_w = PW'(d_eff);
    last_ph = (d_eff_w << 1) - PW'(1);
    push    = din_valid & ~flush;
    pair    = push & (phase_q >= d_eff_w);
    fill    = push & (phase_q < d_eff_w);
    last    = (phase_q == last_ph);
    wr_addr = AW'(phase_q);
    rd_addr = AW'(phase_q - d_eff_w);

    phase_d   = phase_q;
    depth_r_d = depth_r_q;
    if (flush) begin
      phase_d = '0;
    end else if (push) begin
      if (phase_q == '0) depth_r_d = depth_clamp;
      phase_d = last ? '0 : phase_q + PW'(1);
    end
    bfly_en_d    = pair;
    frame_done_d = pair & last;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q      <= '0;
      depth_r_q    <= DW'(MAX_DEPTH);
      bfly_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      depth_r_q    <= depth_r_d;
      bfly_en_q    <= bfly_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fft_pair_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_DEPTH (MAX_DEPTH),
      .AW        (AW)
    ) u_lane (
      .clk    (clk),
      .rstn   (rstn),
      .wr_en  (fill),
      .wr_addr(wr_addr),
      .rd_en  (pair),
      .rd_addr(rd_addr),
      .din_i  (din_i[g]),
      .din_q  (din_q[g]),
      .a_i    (dout_a_i[g]),
      .a_q    (dout_a_q[g]),
      .b_i    (dout_b_i[g]),
      .b_q    (dout_b_q[g])
    );
  end

  assign bfly_en    = bfly_en_q;
  assign frame_done = frame_done_q;
  assign busy       = (phase_q != '0);
endmodule

// File: tb/tb_fft_pair_buf.sv
// Directed table-driven bench for fft_pair_buf (default parameters).
module tb_fft_pair_buf;
  localparam int DATA_WIDTH = 9;
  localparam int LANES      = 16;
  localparam int MAX_DEPTH  = 16;
  localparam int TDW        = 5;

  logic clk, rstn, flush, din_valid;
  logic [TDW-1:0] cfg_depth;
  logic [LANES-1:0][DATA_WIDTH-1:0] din_i, din_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] dout_a_i, dout_a_q, dout_b_i, dout_b_q;
  logic bfly_en, frame_done, busy;

  int tests = 0;
  int fails = 0;

  fft_pair_buf #(.DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .cfg_depth(cfg_depth), .flush(flush),
    .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
    .dout_a_i(dout_a_i), .dout_a_q(dout_a_q), .dout_b_i(dout_b_i), .dout_b_q(dout_b_q),
    .bfly_en(bfly_en), .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs, then expected flags and (optionally) the pair.
  typedef struct {
    bit v; bit f; int cfg; int k;
    bit eb; bit ed; bit ebusy; bit cd; int ka; int kb;
  } rec_t;
  rec_t tbl[$];

  // Vector k: lane j I = (k*16+j) mod 256, Q = -I.
  function automatic logic [LANES-1:0][DATA_WIDTH-1:0] vec_i(input int k);
    for (int j = 0; j < LANES; j++) begin
      int x;
      x = (k*16 + j) % 256;
      vec_i[j] = x[DATA_WIDTH-1:0];
    end
  endfunction

  function automatic logic [LANES-1:0][DATA_WIDTH-1:0] vec_q(input int k);
    for (int j = 0; j < LANES; j++) begin
      int x;
      x = -((k*16 + j) % 256);
      vec_q[j] = x[DATA_WIDTH-1:0];
    end
  endfunction

  function automatic void add_rec(input bit v, input bit f, input int cfg, input int k,
                                  input bit eb, input bit ed, input bit ebusy,
                                  input bit cd, input int ka, input int kb);
    rec_t r;
    r.v = v; r.f = f; r.cfg = cfg; r.k = k;
    r.eb = eb; r.ed = ed; r.ebusy = ebusy; r.cd = cd; r.ka = ka; r.kb = kb;
    tbl.push_back(r);
  endfunction

  // Full frame of 2*d pushes of vectors k0.., optionally with an idle cycle after each.
  function automatic void add_frame(input int d, input int cfg, input int k0, input bit gap);
    for (int n = 0; n < 2*d; n++) begin
      add_rec(1, 0, cfg, k0+n, n >= d, n == 2*d-1, n != 2*d-1, n >= d, k0+n-d, k0+n);
      if (gap) add_rec(0, 0, cfg, 0, 0, 0, n != 2*d-1, 0, 0, 0);
    end
  endfunction

  task automatic chk(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s rec=%0d act=%h exp=%h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input rec_t r, input int idx);
    din_valid = r.v;
    flush     = r.f;
    cfg_depth = TDW'(r.cfg);
    din_i     = vec_i(r.k);
    din_q     = vec_q(r.k);
    @(posedge clk);
    #1;
    chk("bfly_en", idx, 256'(bfly_en), 256'(r.eb));
    chk("frame_done", idx, 256'(frame_done), 256'(r.ed));
    chk("busy", idx, 256'(busy), 256'(r.ebusy));
    if (r.cd) begin
      chk("dout_a_i", idx, 256'(dout_a_i), 256'(vec_i(r.ka)));
      chk("dout_a_q", idx, 256'(dout_a_q), 256'(vec_q(r.ka)));
      chk("dout_b_i", idx, 256'(dout_b_i), 256'(vec_i(r.kb)));
      chk("dout_b_q", idx, 256'(dout_b_q), 256'(vec_q(r.kb)));
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_bfly_en"}, -1, 256'(bfly_en), 256'(0));
    chk({nm, "_frame_done"}, -1, 256'(frame_done), 256'(0));
    chk({nm, "_busy"}, -1, 256'(busy), 256'(0));
    chk({nm, "_dout_a_i"}, -1, 256'(dout_a_i), 256'(0));
    chk({nm, "_dout_a_q"}, -1, 256'(dout_a_q), 256'(0));
    chk({nm, "_dout_b_i"}, -1, 256'(dout_b_i), 256'(0));
    chk({nm, "_dout_b_q"}, -1, 256'(dout_b_q), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n_main, n_pre;
    // Main table.
    add_frame(16, 16, 0, 0);          // default depth, 32 pushes
    add_frame(4, 4, 32, 0);           // depth 4, two frames back-to-back
    add_frame(4, 4, 40, 0);
    add_frame(16, 0, 48, 0);          // cfg 0 clamps to 16
    add_frame(1, 1, 80, 0);           // depth 1
    add_frame(1, 1, 82, 0);
    add_frame(8, 8, 100, 1);          // gapped depth 8
    // Mid-frame cfg change is ignored, then flush with din_valid.
    for (int n = 0; n < 5; n++) add_rec(1, 0, 8, 200+n, 0, 0, 1, 0, 0, 0);
    for (int n = 5; n < 8; n++) add_rec(1, 0, 2, 200+n, 0, 0, 1, 0, 0, 0);
    add_rec(1, 0, 2, 208, 1, 0, 1, 1, 200, 208);
    add_rec(1, 1, 2, 209, 0, 0, 0, 1, 200, 208);   // dropped; outputs hold
    add_frame(2, 2, 210, 0);
    n_main = tbl.size();
    // Partial depth-16 frame, stopped four pairs into the second half.
    for (int n = 0; n < 20; n++)
      add_rec(1, 0, 16, 300+n, n >= 16, 0, 1, n >= 16, 300+n-16, 300+n);
    n_pre = tbl.size();
    add_frame(16, 16, 500, 0);        // fresh frame after reset

    rstn = 1'b0; flush = 1'b0; din_valid = 1'b0; cfg_depth = '0;
    din_i = '0; din_q = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("post_reset");

    for (int i = 0; i < n_main; i++) apply(tbl[i], i);
    for (int i = n_main; i < n_pre; i++) apply(tbl[i], i);

    // Asynchronous reset between edges while in the pair half.
    din_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("async_reset");
    #2;
    rstn = 1'b1;
    for (int i = n_pre; i < tbl.size(); i++) apply(tbl[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
